// File: rtl/sched_pkg.sv
// Shared constants and state encoding for the energy sample scheduler.
package sched_pkg;

  localparam int unsigned N_CH_DEF    = 4;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SCAN_ENC = 2'd1;
  localparam logic [1:0] ST_REQ_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SCAN = ST_SCAN_ENC,
    ST_REQ  = ST_REQ_ENC,
    ST_DONE = ST_DONE_ENC
  } sched_state_t;

  // Index width for a vector of n entries, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted bit plus a valid flag.
module sched_prio_enc #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N_CH-1:0] i_vec,
  output logic [CH_W-1:0] o_idx_c,
  output logic            o_valid_c
);

  // Walk from the top down so the lowest set bit is the last to win.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx_c   = CH_W'(i);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/energy_sample_scheduler.sv
// Frame sequencer for the energy-supervision measurement front-end.
// Each accepted tick latches the channel mask and walks the enabled channels
// lowest-first through a Req/Ack handshake with the shared measurement unit.
// Optional: define SCHED_TIMEOUT_EN to bound each Req wait to TIMEOUT cycles
// and record stuck channels in o_err_mask.
module energy_sample_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_enable,
  input  logic [N_CH-1:0]  i_ch_mask,
  input  logic             i_ack,
  input  logic             i_clr_flags,
  output logic             o_req,
  output logic [CH_W-1:0]  o_ch_sel,
  output logic             o_frame_start,
  output logic             o_frame_done,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_frame_count,
  output logic [N_CH-1:0]  o_err_mask
);

  sched_state_t      r_state;
  logic [N_CH-1:0]   r_pend;
  logic [CH_W-1:0]   r_ch_sel;
  logic              r_req;
  logic              r_frame_start;
  logic              r_frame_done;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_frame_count;

  logic [CH_W-1:0]   w_next_idx;
  logic              w_next_valid;
  logic [N_CH-1:0]   w_sel_bit;

  assign w_sel_bit = N_CH'(1) << r_ch_sel;

  sched_prio_enc #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_prio_enc (
    .i_vec     (r_pend),
    .o_idx_c   (w_next_idx),
    .o_valid_c (w_next_valid)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WAIT_W = clog2_min1(TIMEOUT);

  logic [WAIT_W-1:0] r_wait;
  logic [N_CH-1:0]   r_err_mask;
`endif

  // Frame FSM with all outputs, flags and counters registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_pend        <= '0;
      r_ch_sel      <= '0;
      r_req         <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
`ifdef SCHED_TIMEOUT_EN
      r_wait        <= '0;
      r_err_mask    <= '0;
`endif
    end else begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;

      // A tick while busy is dropped; setting beats clearing.
      if (i_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (i_clr_flags) begin
        r_overrun <= 1'b0;
      end

`ifdef SCHED_TIMEOUT_EN
      if (i_clr_flags) begin
        r_err_mask <= '0;
      end
`endif

      if ((r_state != ST_IDLE) && !i_enable) begin
        // Abort outranks Ack: drop the frame without completing it.
        r_state <= ST_IDLE;
        r_req   <= 1'b0;
        r_pend  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_tick && i_enable && (|i_ch_mask)) begin
              r_pend        <= i_ch_mask;
              r_state       <= ST_SCAN;
              r_frame_start <= 1'b1;
            end
          end
          ST_SCAN: begin
            if (w_next_valid) begin
              r_ch_sel <= w_next_idx;
              r_req    <= 1'b1;
              r_state  <= ST_REQ;
`ifdef SCHED_TIMEOUT_EN
              r_wait   <= '0;
`endif
            end else begin
              r_state       <= ST_DONE;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + CNT_W'(1);
            end
          end
          ST_REQ: begin
            if (i_ack) begin
              r_req   <= 1'b0;
              r_pend  <= r_pend & ~w_sel_bit;
              r_state <= ST_SCAN;
            end
`ifdef SCHED_TIMEOUT_EN
            else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
              r_err_mask[r_ch_sel] <= 1'b1;
              r_req   <= 1'b0;
              r_pend  <= r_pend & ~w_sel_bit;
              r_state <= ST_SCAN;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
`endif
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_req         = r_req;
  assign o_ch_sel      = r_ch_sel;
  assign o_frame_start = r_frame_start;
  assign o_frame_done  = r_frame_done;
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;

`ifdef SCHED_TIMEOUT_EN
  assign o_err_mask = r_err_mask;
`else
  assign o_err_mask = '0;
`endif

endmodule
